// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: three debounced buttons, a start/stop/lap/clear FSM, a gated
// centisecond prescaler and a 4-digit BCD time counter with lap freeze and overflow.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 120000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BTN_START,
  input  logic        BTN_LAP,
  input  logic        BTN_CLEAR,
  output logic [15:0] display_value,
  output logic        running,
  output logic        lap_frozen,
  output logic        overflow,
  output logic        tick,
  output logic [1:0]  fsm_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // fsm_state encoding: 0 IDLE, 1 RUN, 2 LAP, 3 STOP
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [15:0]     count;
  logic [15:0]     lap_reg;

  // Button lanes: bit 0 start, bit 1 lap, bit 2 clear
  logic [2:0]      btn_raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      db;
  logic [2:0]      db_d;
  logic [2:0]      ev;
  logic [DW-1:0]   dcnt [3];

  logic            ev_start;
  logic            ev_lap;
  logic            ev_clear;

  assign btn_raw  = {BTN_CLEAR, BTN_LAP, BTN_START};
  assign ev_start = ev[0];
  assign ev_lap   = ev[1];
  assign ev_clear = ev[2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      ev    <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      ev    <= db & ~db_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == D_LAST) begin
          db[i]   <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign running       = (state == S_RUN) || (state == S_LAP);
  assign lap_frozen    = (state == S_LAP);
  assign display_value = lap_frozen ? lap_reg : count;
  assign fsm_state     = state;

  // A START event in RUN/LAP always means stopping, so it gates the final increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      presc    <= '0;
      count    <= '0;
      lap_reg  <= '0;
      overflow <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (running && !ev_start) begin
        if (presc == P_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
          count <= bcd_inc(count);
          if (count == 16'h9999) overflow <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      case (state)
        S_IDLE: begin
          if (ev_start) state <= S_RUN;
        end
        S_RUN: begin
          if (ev_start) begin
            state <= S_STOP;
          end else if (!ev_clear && ev_lap) begin
            state   <= S_LAP;
            lap_reg <= count;
          end
        end
        S_LAP: begin
          if (ev_start) begin
            state <= S_STOP;
          end else if (ev_clear) begin
            state <= S_RUN;
          end else if (ev_lap) begin
            lap_reg <= count;
          end
        end
        S_STOP: begin
          if (ev_start) begin
            state <= S_RUN;
          end else if (ev_clear) begin
            state    <= S_IDLE;
            count    <= '0;
            presc    <= '0;
            lap_reg  <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against an integer-arithmetic reference model,
// compared every cycle through an expected-value queue.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_LAP  = 2;
  localparam int ST_STOP = 3;

  logic        CLK;
  logic        RST_N;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] display_value;
  logic        running;
  logic        lap_frozen;
  logic        overflow;
  logic        tick;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_err    = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN_START(btn_start),
    .BTN_LAP(btn_lap),
    .BTN_CLEAR(btn_clear),
    .display_value(display_value),
    .running(running),
    .lap_frozen(lap_frozen),
    .overflow(overflow),
    .tick(tick),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is an integer 0..9999, the lap value another integer; BCD only at the output.
  int m_f1[3], m_s[3], m_db[3], m_dbd[3], m_run[3], m_ev[3];
  int m_state, m_p, m_cnt, m_lap, m_ovf, m_tick;
  int o_s, o_l, o_c, nxt, cap, clr, was_run, now_run;
  logic [2:0] raw;
  logic [21:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_f1[i] = 0; m_s[i] = 0; m_db[i] = 0; m_dbd[i] = 0; m_run[i] = 0; m_ev[i] = 0;
    end
    m_state = ST_IDLE; m_p = 0; m_cnt = 0; m_lap = 0; m_ovf = 0; m_tick = 0;
  endtask

  initial model_reset();

  always @(posedge CLK) begin
    if (!RST_N) begin
      model_reset();
    end else begin
      raw = {btn_clear, btn_lap, btn_start};
      o_s = m_ev[0]; o_l = m_ev[1]; o_c = m_ev[2];
      for (int i = 0; i < 3; i++) begin
        m_ev[i]  = (m_db[i] == 1 && m_dbd[i] == 0) ? 1 : 0;
        m_dbd[i] = m_db[i];
        if (m_s[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i]  = m_s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s[i]  = m_f1[i];
        m_f1[i] = int'(raw[i]);
      end
      nxt = m_state; cap = 0; clr = 0;
      if (o_s != 0) begin
        nxt = (m_state == ST_IDLE || m_state == ST_STOP) ? ST_RUN : ST_STOP;
      end else if (o_c != 0) begin
        if (m_state == ST_LAP) nxt = ST_RUN;
        else if (m_state == ST_STOP) begin nxt = ST_IDLE; clr = 1; end
      end else if (o_l != 0) begin
        if (m_state == ST_RUN || m_state == ST_LAP) begin nxt = ST_LAP; cap = 1; end
      end
      was_run = (m_state == ST_RUN || m_state == ST_LAP) ? 1 : 0;
      now_run = (nxt == ST_RUN || nxt == ST_LAP) ? 1 : 0;
      m_tick = 0;
      if (cap != 0) m_lap = m_cnt;
      if (was_run != 0 && now_run != 0) begin
        m_p++;
        if (m_p == TD) begin
          m_p    = 0;
          m_tick = 1;
          m_cnt  = (m_cnt + 1) % 10000;
          if (m_cnt == 0) m_ovf = 1;
        end
      end
      if (clr != 0) begin m_cnt = 0; m_p = 0; m_lap = 0; m_ovf = 0; end
      m_state = nxt;
    end
    exp_q.push_back({2'(m_state), m_tick[0], m_ovf[0], (m_state == ST_LAP),
                     (m_state == ST_RUN || m_state == ST_LAP),
                     to_bcd(m_state == ST_LAP ? m_lap : m_cnt)});
  end

  // ---------------- scoreboard ----------------
  logic [21:0] e;
  always @(negedge CLK) begin
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("display",    32'(display_value), 32'(e[15:0]));
      check("running",    32'(running),       32'(e[16]));
      check("lap_frozen", 32'(lap_frozen),    32'(e[17]));
      check("overflow",   32'(overflow),      32'(e[18]));
      check("tick",       32'(tick),          32'(e[19]));
      check("state",      32'(fsm_state),     32'(e[21:20]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge CLK);
    {btn_clear, btn_lap, btn_start} = mask;
    idle(hold);
    {btn_clear, btn_lap, btn_start} = 3'b000;
  endtask

  task automatic goto_run();
    for (int k = 0; k < 6; k++) begin
      if (m_state == ST_RUN) break;
      press(m_state == ST_LAP ? 3'b100 : 3'b001, 4);
      idle(8);
    end
    check("goto_run", 32'(m_state), ST_RUN);
  endtask

  logic [5:0] bounce;
  int r;

  initial begin
    RST_N = 1'b1;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    #2 RST_N = 1'b0;
    idle(4);
    check("rst_display", 32'(display_value), 32'h0);
    check("rst_state",   32'(fsm_state),     ST_IDLE);
    RST_N = 1'b1;
    idle(3);

    // START held 10 cycles, then let it count a few ticks
    press(3'b001, 10);
    idle(40);
    // LAP freeze, then CLEAR unfreezes while running
    press(3'b010, 5);
    idle(20);
    press(3'b100, 5);
    idle(15);
    // START to STOP, CLEAR to IDLE, LAP ignored in IDLE
    press(3'b001, 5);
    idle(10);
    press(3'b100, 5);
    idle(10);
    check("idle_display", 32'(display_value), 32'h0);
    press(3'b010, 5);
    idle(10);
    // short glitch, then a bouncing press
    press(3'b001, 2);
    idle(10);
    check("glitch_state", 32'(fsm_state), ST_IDLE);
    bounce = 6'b101111;
    for (int i = 5; i >= 0; i--) begin
      @(negedge CLK);
      btn_start = bounce[i];
    end
    @(negedge CLK);
    btn_start = 1'b0;
    idle(12);
    check("bounce_state", 32'(fsm_state), ST_RUN);
    // simultaneous START+CLEAR while running
    idle(9);
    press(3'b101, 5);
    idle(12);
    check("start_clear", 32'(fsm_state), ST_STOP);

    // random button traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: press(3'b001, $urandom_range(1, 7));
        4, 5:       press(3'b010, $urandom_range(1, 7));
        6, 7:       press(3'b100, $urandom_range(1, 7));
        8:          press(3'b101, $urandom_range(1, 7));
        default:    press(3'b011, $urandom_range(1, 7));
      endcase
      idle($urandom_range(0, 15));
    end

    // run long enough to wrap 9999 -> 0000, then STOP and CLEAR
    idle(10);
    goto_run();
    idle(TD * 10010);
    check("ovf_set", 32'(overflow), 32'd1);
    press(3'b001, 4);
    idle(10);
    press(3'b100, 4);
    idle(10);
    check("ovf_cleared", 32'(overflow), 32'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
